// File: rtl/izhikevich_scheduler.sv
// Time-multiplexes one izhikevich_core over NEURONS neurons: per-neuron v/w/i banks,
// one LOAD/APPLY/STORE pass per neuron per sweep, spike vector and count published on DONE.
module izhikevich_scheduler #(
  parameter int N       = 18,
  parameter int Q       = 10,
  parameter int NEURONS = 8,
  parameter int IDX_W   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_sel,
  input  logic [IDX_W-1:0]   cfg_addr,
  input  logic [N-1:0]       cfg_data,
  output logic [N-1:0]       rd_v,
  output logic [N-1:0]       rd_w,
  output logic               core_rst,
  output logic               core_apply,
  output logic [N-1:0]       core_v_init,
  output logic [N-1:0]       core_w_init,
  output logic [N-1:0]       core_i,
  input  logic [N-1:0]       core_voltage,
  input  logic [N-1:0]       core_w,
  input  logic               core_is_spiking,
  output logic               busy,
  output logic               done,
  output logic [NEURONS-1:0] spike_vec,
  output logic [IDX_W:0]     spike_count,
  output logic [15:0]        step_count,
  output logic [2:0]         state_dbg
);

  if (Q >= N || NEURONS < 1 || IDX_W < 1 || (2 ** IDX_W) < NEURONS) begin : g_bad_params
    $error("izhikevich_scheduler: inconsistent parameters");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_APPLY = 3'd2,
    S_STORE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NEURONS - 1);
  localparam logic [IDX_W:0]   NEURONS_W = (IDX_W + 1)'(NEURONS);

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx;
  logic [NEURONS-1:0] shadow;
  logic [N-1:0]       v_bank [NEURONS];
  logic [N-1:0]       w_bank [NEURONS];
  logic [N-1:0]       i_bank [NEURONS];
  logic               addr_ok;
  logic               cfg_write;

  function automatic logic [IDX_W:0] popcount(input logic [NEURONS-1:0] bits);
    logic [IDX_W:0] cnt;
    cnt = '0;
    for (int k = 0; k < NEURONS; k++) cnt = cnt + (IDX_W + 1)'(bits[k]);
    return cnt;
  endfunction

  // Non-power-of-two neuron counts leave unused addresses; they read as 0 and ignore writes.
  assign addr_ok   = ({1'b0, cfg_addr} < NEURONS_W);
  assign cfg_write = (state == S_IDLE) && cfg_we && addr_ok && (cfg_sel != 2'd3);
  assign rd_v      = addr_ok ? v_bank[cfg_addr] : '0;
  assign rd_w      = addr_ok ? w_bank[cfg_addr] : '0;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign state_dbg = state;

  always_comb begin
    state_nxt   = state;
    core_rst    = 1'b0;
    core_apply  = 1'b0;
    core_v_init = '0;
    core_w_init = '0;
    core_i      = '0;
    case (state)
      S_IDLE: if (start) state_nxt = S_LOAD;
      S_LOAD: begin
        core_rst    = 1'b1;
        core_v_init = v_bank[idx];
        core_w_init = w_bank[idx];
        core_i      = i_bank[idx];
        state_nxt   = S_APPLY;
      end
      S_APPLY: begin
        core_apply = 1'b1;
        core_i     = i_bank[idx];
        state_nxt  = S_STORE;
      end
      S_STORE: state_nxt = (idx == LAST_IDX) ? S_DONE : S_LOAD;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      idx         <= '0;
      shadow      <= '0;
      spike_vec   <= '0;
      spike_count <= '0;
      step_count  <= '0;
      for (int k = 0; k < NEURONS; k++) begin
        v_bank[k] <= '0;
        w_bank[k] <= '0;
        i_bank[k] <= '0;
      end
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          // A write coinciding with start commits first, so LOAD of neuron 0 sees it.
          if (cfg_write) begin
            case (cfg_sel)
              2'd0:    v_bank[cfg_addr] <= cfg_data;
              2'd1:    w_bank[cfg_addr] <= cfg_data;
              2'd2:    i_bank[cfg_addr] <= cfg_data;
              default: ;
            endcase
          end
          if (start) begin
            idx    <= '0;
            shadow <= '0;
          end
        end
        S_STORE: begin
          v_bank[idx] <= core_voltage;
          w_bank[idx] <= core_w;
          shadow[idx] <= core_is_spiking;
          if (idx != LAST_IDX) idx <= idx + 1'b1;
        end
        S_DONE: begin
          spike_vec   <= shadow;
          spike_count <= popcount(shadow);
          step_count  <= step_count + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_izhikevich_scheduler.sv
// Bench for izhikevich_scheduler: a small behavioural neuron core closes the loop, and a
// sweep-level reference model predicts banks, spikes and counters.
module tb_izhikevich_scheduler;

  localparam int N         = 18;
  localparam int Q         = 10;
  localparam int NR        = 4;
  localparam int IW        = 2;
  localparam int S         = 1 << Q;
  localparam int SWEEP_LAT = 3 * NR + 1;
  localparam int V_TH      = 30 * S;
  localparam int C_RST     = -65 * S;
  localparam int D_INC     = 8 * S;

  logic          clk, rst, start, cfg_we;
  logic [1:0]    cfg_sel;
  logic [IW-1:0] cfg_addr;
  logic [N-1:0]  cfg_data, rd_v, rd_w;
  logic          core_rst, core_apply, core_is_spiking;
  logic [N-1:0]  core_v_init, core_w_init, core_i, core_voltage, core_w;
  logic          busy, done;
  logic [NR-1:0] spike_vec;
  logic [IW:0]   spike_count;
  logic [15:0]   step_count;
  logic [2:0]    state_dbg;

  int n_cmp, n_fail;
  int ref_v [NR], ref_w [NR], ref_i [NR], prev_v [NR];
  logic [NR-1:0]  ref_spk;
  int             ref_steps;
  logic [2*N-1:0] exp_q[$];
  logic [N+1:0]   ctl_log[$];

  izhikevich_scheduler #(.N(N), .Q(Q), .NEURONS(NR), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .rd_v(rd_v), .rd_w(rd_w),
    .core_rst(core_rst), .core_apply(core_apply), .core_v_init(core_v_init),
    .core_w_init(core_w_init), .core_i(core_i), .core_voltage(core_voltage),
    .core_w(core_w), .core_is_spiking(core_is_spiking), .busy(busy), .done(done),
    .spike_vec(spike_vec), .spike_count(spike_count), .step_count(step_count),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- neuron core stand-in ----------------
  logic signed [N-1:0] cm_v, cm_w;
  initial begin
    core_voltage    = '0;
    core_w          = '0;
    core_is_spiking = 1'b0;
  end
  always @(posedge clk) begin
    if (core_rst) begin
      cm_v <= core_v_init;
      cm_w <= core_w_init;
    end
    if (core_apply) begin
      if (cm_v >= V_TH) begin
        core_voltage    <= N'(C_RST);
        core_w          <= N'(int'(cm_w) + D_INC);
        core_is_spiking <= 1'b1;
      end else begin
        core_voltage    <= N'(int'(cm_v) + int'($signed(core_i)) - (int'(cm_w) >>> 3));
        core_w          <= cm_w;
        core_is_spiking <= 1'b0;
      end
    end
  end

  // Core control exclusivity and quiet outputs while idle.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      n_cmp++;
      if (core_rst === 1'b1 && core_apply === 1'b1) begin
        n_fail++;
        $display("FAIL ctl_exclusive: core_rst=%b core_apply=%b required not both 1", core_rst, core_apply);
      end
      if (busy === 1'b0) begin
        n_cmp++;
        if ({core_rst, core_apply, core_v_init, core_w_init, core_i} !== '0) begin
          n_fail++;
          $display("FAIL idle_core_outputs: rst=%b apply=%b v=%h w=%h i=%h required all 0",
                   core_rst, core_apply, core_v_init, core_w_init, core_i);
        end
      end
    end
  end

  // ---------------- reference model ----------------
  task automatic model_sweep();
    ref_spk = '0;
    for (int k = 0; k < NR; k++) begin
      prev_v[k] = ref_v[k];
      if (ref_v[k] >= V_TH) begin
        ref_spk[k] = 1'b1;
        ref_v[k]   = C_RST;
        ref_w[k]   = ref_w[k] + D_INC;
      end else begin
        ref_v[k] = ref_v[k] + ref_i[k] - (ref_w[k] >>> 3);
      end
    end
    ref_steps++;
  endtask

  task automatic model_clear();
    for (int k = 0; k < NR; k++) begin
      ref_v[k] = 0; ref_w[k] = 0; ref_i[k] = 0;
    end
    ref_steps = 0;
  endtask

  // ---------------- drivers ----------------
  task automatic do_reset();
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_clear();
  endtask

  task automatic cfg_write(input logic [1:0] sel, input int k, input int val);
    @(negedge clk);
    cfg_we = 1'b1; cfg_sel = sel; cfg_addr = IW'(k); cfg_data = N'(val);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic load_all();
    for (int k = 0; k < NR; k++) begin
      cfg_write(2'd0, k, ref_v[k]);
      cfg_write(2'd1, k, ref_w[k]);
      cfg_write(2'd2, k, ref_i[k]);
    end
  endtask

  // Pulses start and returns in the first idle cycle after done; lat = cycle of done (1 = cycle after start edge).
  task automatic run_sweep(output int lat);
    lat = -1;
    ctl_log.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 1; c <= 3 * SWEEP_LAT; c++) begin
      ctl_log.push_back({core_rst, core_apply, core_v_init});
      if (done === 1'b1) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_cmp++;
    if ({busy, done, spike_vec, spike_count, step_count, core_rst, core_apply} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b done=%b spk=%b cnt=%0d steps=%0d rst=%b apply=%b required all 0",
               busy, done, spike_vec, spike_count, step_count, core_rst, core_apply);
    end
    for (int k = 0; k < NR; k++) begin
      cfg_addr = IW'(k); #1;
      n_cmp++;
      if ({rd_v, rd_w} !== '0) begin
        n_fail++;
        $display("FAIL reset_banks[%0d]: v=%h w=%h required 0", k, rd_v, rd_w);
      end
    end
  endtask

  task automatic test_quiet_sweep();
    int lat;
    for (int k = 0; k < NR; k++) begin
      ref_v[k] = C_RST; ref_w[k] = 0; ref_i[k] = 0;
    end
    load_all();
    run_sweep(lat);
    model_sweep();
    n_cmp++;
    if (lat !== SWEEP_LAT) begin
      n_fail++; $display("FAIL quiet_latency: got %0d required %0d", lat, SWEEP_LAT);
    end
    n_cmp++;
    if (spike_vec !== 4'b0000 || step_count !== 16'd1) begin
      n_fail++; $display("FAIL quiet_result: spk=%b steps=%0d required 0000 / 1", spike_vec, step_count);
    end
    for (int c = 0; c < SWEEP_LAT && c < ctl_log.size(); c++) begin
      logic [1:0] exp_ctl;
      exp_ctl = (c == SWEEP_LAT - 1) ? 2'b00 : (c % 3 == 0) ? 2'b10 : (c % 3 == 1) ? 2'b01 : 2'b00;
      n_cmp++;
      if (ctl_log[c][N+1:N] !== exp_ctl) begin
        n_fail++; $display("FAIL quiet_ctl_cycle%0d: rst/apply=%b required %b", c + 1, ctl_log[c][N+1:N], exp_ctl);
      end
    end
  endtask

  task automatic test_single_spiker();
    int lat;
    ref_v[2] = 35 * S; ref_w[2] = 0;
    cfg_write(2'd0, 2, ref_v[2]);
    cfg_write(2'd1, 2, ref_w[2]);
    run_sweep(lat);
    model_sweep();
    n_cmp++;
    if (spike_vec !== 4'b0100 || spike_count !== 3'd1) begin
      n_fail++; $display("FAIL spiker_vec: spk=%b cnt=%0d required 0100 / 1", spike_vec, spike_count);
    end
    cfg_addr = 2'd2; #1;
    n_cmp++;
    if (rd_v !== N'(C_RST) || rd_w !== N'(8 * S)) begin
      n_fail++; $display("FAIL spiker_state: v=%h w=%h required %h %h", rd_v, rd_w, N'(C_RST), N'(8 * S));
    end
  endtask

  task automatic test_drive_current();
    int lat, sweeps;
    do_reset();
    for (int k = 0; k < NR; k++) begin
      ref_v[k] = C_RST; ref_w[k] = 0; ref_i[k] = 0;
    end
    ref_i[0] = 10 * S;
    load_all();
    sweeps = 0;
    for (int s = 1; s <= 30; s++) begin
      run_sweep(lat);
      model_sweep();
      sweeps = s;
      n_cmp++;
      if (lat !== SWEEP_LAT || spike_vec !== ref_spk || spike_vec[3:1] !== 3'b000 || step_count !== 16'(s)) begin
        n_fail++;
        $display("FAIL drive_sweep%0d: lat=%0d spk=%b steps=%0d required %0d %b %0d",
                 s, lat, spike_vec, step_count, SWEEP_LAT, ref_spk, s);
      end
      if (spike_vec[0] === 1'b1) break;
    end
    // -65 mV rises 10 per sweep: 35 after sweep 10, so sweep 11 fires.
    n_cmp++;
    if (sweeps !== 11 || spike_vec[0] !== 1'b1) begin
      n_fail++; $display("FAIL drive_first_spike: sweep=%0d bit0=%b required 11 / 1", sweeps, spike_vec[0]);
    end
  endtask

  task automatic test_protocol_abuse();
    int dones, lat;
    dones = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 4) begin
        start = 1'b1; cfg_we = 1'b1; cfg_sel = 2'd0; cfg_addr = 2'd1; cfg_data = N'(100 * S);
      end else if (c == 5) begin
        start = 1'b0; cfg_we = 1'b0;
      end
      if (done === 1'b1) dones++;
      @(negedge clk);
    end
    model_sweep();
    n_cmp++;
    if (dones !== 1 || step_count !== 16'(ref_steps)) begin
      n_fail++; $display("FAIL abuse_dones: dones=%0d steps=%0d required 1 / %0d", dones, step_count, ref_steps);
    end
    cfg_addr = 2'd1; #1;
    n_cmp++;
    if (rd_v !== N'(ref_v[1])) begin
      n_fail++; $display("FAIL abuse_v1: got %h required %h", rd_v, N'(ref_v[1]));
    end
    run_sweep(lat);
    model_sweep();
    n_cmp++;
    if (lat !== SWEEP_LAT || spike_vec !== ref_spk || step_count !== 16'(ref_steps)) begin
      n_fail++; $display("FAIL abuse_followup: lat=%0d spk=%b steps=%0d required %0d %b %0d",
                         lat, spike_vec, step_count, SWEEP_LAT, ref_spk, ref_steps);
    end
  endtask

  task automatic test_start_with_write();
    int lat;
    lat = -1;
    ref_v[0] = 35 * S;
    @(negedge clk);
    start = 1'b1; cfg_we = 1'b1; cfg_sel = 2'd0; cfg_addr = 2'd0; cfg_data = N'(ref_v[0]);
    @(negedge clk);
    start = 1'b0; cfg_we = 1'b0;
    for (int c = 1; c <= 3 * SWEEP_LAT; c++) begin
      if (done === 1'b1) begin lat = c; break; end
      @(negedge clk);
    end
    @(negedge clk);
    model_sweep();
    n_cmp++;
    if (lat !== SWEEP_LAT || spike_vec !== ref_spk || spike_vec[0] !== 1'b1) begin
      n_fail++; $display("FAIL start_write: lat=%0d spk=%b required %0d %b", lat, spike_vec, SWEEP_LAT, ref_spk);
    end
  endtask

  task automatic test_back_to_back();
    int first, second, ndone;
    first = -1; second = -1; ndone = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 4 * SWEEP_LAT; c++) begin
      if (done === 1'b1) begin
        ndone++;
        if (ndone == 1) first = c;
        else begin
          second = c; start = 1'b0;
          break;
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    model_sweep();
    model_sweep();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (first !== SWEEP_LAT || second - first !== SWEEP_LAT + 1) begin
      n_fail++; $display("FAIL b2b_timing: first=%0d gap=%0d required %0d %0d", first, second - first, SWEEP_LAT, SWEEP_LAT + 1);
    end
    n_cmp++;
    if (busy !== 1'b0 || step_count !== 16'(ref_steps) || spike_vec !== ref_spk) begin
      n_fail++; $display("FAIL b2b_result: busy=%b steps=%0d spk=%b required 0 %0d %b", busy, step_count, spike_vec, ref_steps, ref_spk);
    end
  endtask

  task automatic test_random_sweeps();
    int lat;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < NR; k++) begin
        ref_v[k] = (int'($urandom_range(0, 120)) - 80) * S + int'($urandom_range(0, S - 1));
        ref_w[k] = int'($urandom_range(0, 16 * S));
        ref_i[k] = int'($urandom_range(0, 8 * S));
      end
      load_all();
      for (int s = 0; s < 4; s++) begin
        run_sweep(lat);
        model_sweep();
        n_cmp++;
        if (lat !== SWEEP_LAT || spike_vec !== ref_spk || spike_count !== 3'($countones(ref_spk))
            || step_count !== 16'(ref_steps)) begin
          n_fail++;
          $display("FAIL rand_sweep r%0d s%0d: lat=%0d spk=%b cnt=%0d steps=%0d required %0d %b %0d %0d",
                   r, s, lat, spike_vec, spike_count, step_count, SWEEP_LAT, ref_spk, $countones(ref_spk), ref_steps);
        end
        for (int k = 0; k < NR; k++) begin
          n_cmp++;
          if (3 * k >= ctl_log.size() || ctl_log[3 * k][N-1:0] !== N'(prev_v[k])) begin
            n_fail++; $display("FAIL rand_load_order r%0d s%0d n%0d: v_init missing or wrong, required %h", r, s, k, N'(prev_v[k]));
          end
        end
        for (int k = 0; k < NR; k++) exp_q.push_back({N'(ref_v[k]), N'(ref_w[k])});
        for (int k = 0; k < NR; k++) begin
          logic [2*N-1:0] exp;
          cfg_addr = IW'(k); #1;
          exp = exp_q.pop_front();
          n_cmp++;
          if ({rd_v, rd_w} !== exp) begin
            n_fail++; $display("FAIL rand_bank r%0d s%0d n%0d: got %h required %h", r, s, k, {rd_v, rd_w}, exp);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    int dones;
    dones = 0;
    do_reset();
    for (int k = 0; k < NR; k++) begin
      ref_v[k] = (int'($urandom_range(1, 60)) - 70) * S; ref_w[k] = S; ref_i[k] = 2 * S;
    end
    load_all();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || core_rst !== 1'b0 || core_apply !== 1'b0) begin
      n_fail++; $display("FAIL midreset_busy: busy=%b rst=%b apply=%b required 0", busy, core_rst, core_apply);
    end
    rst = 1'b1;
    model_clear();
    for (int c = 0; c < 2 * SWEEP_LAT; c++) begin
      if (done === 1'b1) dones++;
      @(negedge clk);
    end
    n_cmp++;
    if (dones !== 0 || step_count !== 16'd0 || spike_vec !== '0) begin
      n_fail++; $display("FAIL midreset_counters: dones=%0d steps=%0d spk=%b required 0", dones, step_count, spike_vec);
    end
    for (int k = 0; k < NR; k++) begin
      cfg_addr = IW'(k); #1;
      n_cmp++;
      if ({rd_v, rd_w} !== {N'(ref_v[k]), N'(ref_w[k])}) begin
        n_fail++; $display("FAIL midreset_bank[%0d]: v=%h w=%h required 0", k, rd_v, rd_w);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_cmp = 0; n_fail = 0;
    rst = 1'b0; start = 1'b0; cfg_we = 1'b0; cfg_sel = '0; cfg_addr = '0; cfg_data = '0;
    model_clear();
    test_reset();
    test_quiet_sweep();
    test_single_spiker();
    test_drive_current();
    test_protocol_abuse();
    test_start_with_write();
    test_back_to_back();
    test_random_sweeps();
    test_reset_mid_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
